// File: rtl/my_struct_package.sv
// Shared cache types: MESI state, cache line layout, set-array opcodes and default geometry.
package my_struct_package;

    localparam int CACHE_SETS = 16384;
    localparam int CACHE_WAYS = 8;
    localparam int TAG_W      = 20;
    localparam int DATA_W     = 32;
    localparam int LRU_W      = 4;   // wide enough for up to 16 ways

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [LRU_W-1:0]  LRU;
        mesi_t             MESI_bits;
    } cache_line_t;

    typedef enum logic [1:0] {
        OP_LOOKUP    = 2'd0,
        OP_WRITE_SET = 2'd1,
        OP_CLEAR     = 2'd2,
        OP_NOP       = 2'd3
    } arr_op_t;

    function automatic cache_line_t cleared_line(input logic [DATA_W-1:0] data,
                                                 input logic [LRU_W-1:0]  lru);
        cache_line_t l;
        l.tag       = '0;
        l.data      = data;
        l.LRU       = lru;
        l.MESI_bits = MESI_I;
        return l;
    endfunction

endpackage

// File: rtl/cache_way_select.sv
// Combinational tag compare and replacement choice over one cache set.
module cache_way_select
    import my_struct_package::*;
#(
    parameter  int WAYS  = CACHE_WAYS,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  cache_line_t [WAYS-1:0] i_lines,
    input  logic [TAG_W-1:0]       i_tag,
    output logic                   o_hit,
    output logic [WAY_W-1:0]       o_hit_way,
    output logic [WAY_W-1:0]       o_victim
);

    logic             w_inv_found;
    logic [WAY_W-1:0] w_inv_way;
    logic             w_lru_found;
    logic [WAY_W-1:0] w_lru_way;

    // NOTE: every signal driven here gets a default before the loop, so no latch can be inferred.
    always_comb begin
        o_hit       = 1'b0;
        o_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_lru_found = 1'b0;
        w_lru_way   = '0;
        for (int j = 0; j < WAYS; j++) begin
            if (!o_hit && i_lines[j].MESI_bits != MESI_I && i_lines[j].tag == i_tag) begin
                o_hit     = 1'b1;
                o_hit_way = WAY_W'(j);
            end
            if (!w_inv_found && i_lines[j].MESI_bits == MESI_I) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(j);
            end
            if (!w_lru_found && i_lines[j].LRU == LRU_W'(WAYS-1)) begin
                w_lru_found = 1'b1;
                w_lru_way   = WAY_W'(j);
            end
        end
        // Invalid way first, then oldest by LRU, else way 0 if the LRU field is corrupt.
        o_victim = w_inv_found ? w_inv_way : (w_lru_found ? w_lru_way : '0);
    end

endmodule

// File: rtl/cache_set_array.sv
// Clocked SETS x WAYS cache line storage with registered lookup, set writeback and clear sweep.
// Optional hit/miss counters are built when CACHE_SET_ARRAY_STATS_EN is defined.
module cache_set_array
    import my_struct_package::*;
#(
    parameter  int SETS  = CACHE_SETS,
    parameter  int WAYS  = CACHE_WAYS,
    localparam int SET_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  arr_op_t                req_op,
    input  logic [SET_W-1:0]       req_set,
    input  logic [TAG_W-1:0]       req_tag,
    input  cache_line_t [WAYS-1:0] wr_lines,
    output logic                   rsp_valid,
    output cache_line_t [WAYS-1:0] rsp_lines,
    output logic                   rsp_hit,
    output logic [WAY_W-1:0]       rsp_hit_way,
    output logic [WAY_W-1:0]       rsp_victim,
    output logic                   busy
`ifdef CACHE_SET_ARRAY_STATS_EN
    ,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
`endif
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [SET_W-1:0]        r_sweep_idx;
    cache_line_t [WAYS-1:0]  r_mem [SETS];

    logic                    r_rsp_valid;
    cache_line_t [WAYS-1:0]  r_rsp_lines;
    logic                    r_rsp_hit;
    logic [WAY_W-1:0]        r_rsp_hit_way;
    logic [WAY_W-1:0]        r_rsp_victim;

    logic                    w_accept;
    cache_line_t [WAYS-1:0]  w_rd_lines;
    cache_line_t [WAYS-1:0]  w_clear_lines;
    cache_line_t [WAYS-1:0]  w_set0_lines;
    logic                    w_hit;
    logic [WAY_W-1:0]        w_hit_way;
    logic [WAY_W-1:0]        w_victim;

    assign busy       = (r_state == ST_SWEEP);
    assign req_ready  = !busy;
    assign w_accept   = req_valid && req_ready;
    assign w_rd_lines = r_mem[req_set];

    always_comb begin
        w_clear_lines = '0;
        w_set0_lines  = '0;
        for (int j = 0; j < WAYS; j++) begin
            w_clear_lines[j] = cleared_line(DATA_W'(r_sweep_idx), LRU_W'(WAYS-1-j));
            w_set0_lines[j]  = cleared_line('0, LRU_W'(WAYS-1-j));
        end
    end

    cache_way_select #(.WAYS(WAYS)) u_way_select (
        .i_lines   (w_rd_lines),
        .i_tag     (req_tag),
        .o_hit     (w_hit),
        .o_hit_way (w_hit_way),
        .o_victim  (w_victim)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SWEEP;
            r_sweep_idx <= '0;
        end else begin
            case (r_state)
                ST_SWEEP: begin
                    r_sweep_idx <= r_sweep_idx + 1'b1;
                    if (r_sweep_idx == SET_W'(SETS-1)) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_accept && req_op == OP_CLEAR) begin
                        r_state     <= ST_SWEEP;
                        r_sweep_idx <= '0;
                    end
                end
                default: r_state <= ST_SWEEP;
            endcase
        end
    end

    // NOTE: the storage has no reset branch; the sweep that follows reset initialises every set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_SWEEP)
                r_mem[r_sweep_idx] <= w_clear_lines;
            else if (w_accept && req_op == OP_WRITE_SET)
                r_mem[req_set] <= wr_lines;
        end
    end

    // Response registers hold their contents between lookups; only the valid flag pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_lines   <= w_set0_lines;
            r_rsp_hit     <= 1'b0;
            r_rsp_hit_way <= '0;
            r_rsp_victim  <= '0;
        end else begin
            r_rsp_valid <= w_accept && req_op == OP_LOOKUP;
            if (w_accept && req_op == OP_LOOKUP) begin
                r_rsp_lines   <= w_rd_lines;
                r_rsp_hit     <= w_hit;
                r_rsp_hit_way <= w_hit_way;
                r_rsp_victim  <= w_victim;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_lines   = r_rsp_lines;
    assign rsp_hit     = r_rsp_hit;
    assign rsp_hit_way = r_rsp_hit_way;
    assign rsp_victim  = r_rsp_victim;

`ifdef CACHE_SET_ARRAY_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (reset || (w_accept && req_op == OP_CLEAR)) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_rsp_valid) begin
            if (r_rsp_hit && r_hit_count != 32'hFFFF_FFFF)
                r_hit_count <= r_hit_count + 32'd1;
            if (!r_rsp_hit && r_miss_count != 32'hFFFF_FFFF)
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_set_array.sv
// Directed bench for cache_set_array with SETS=16, WAYS=8; hit/miss counters checked when CACHE_SET_ARRAY_STATS_EN is defined.
module tb_cache_set_array;
    import my_struct_package::*;

    localparam int SETS  = 16;
    localparam int WAYS  = 8;
    localparam int SET_W = 4;
    localparam int WAY_W = 3;

    typedef cache_line_t [WAYS-1:0] set_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    arr_op_t          req_op;
    logic [SET_W-1:0] req_set;
    logic [TAG_W-1:0] req_tag;
    set_t             wr_lines;
    logic             rsp_valid;
    set_t             rsp_lines;
    logic             rsp_hit;
    logic [WAY_W-1:0] rsp_hit_way;
    logic [WAY_W-1:0] rsp_victim;
    logic             busy;
`ifdef CACHE_SET_ARRAY_STATS_EN
    logic [31:0]      hit_count;
    logic [31:0]      miss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cache_set_array #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_set     (req_set),
        .req_tag     (req_tag),
        .wr_lines    (wr_lines),
        .rsp_valid   (rsp_valid),
        .rsp_lines   (rsp_lines),
        .rsp_hit     (rsp_hit),
        .rsp_hit_way (rsp_hit_way),
        .rsp_victim  (rsp_victim),
        .busy        (busy)
`ifdef CACHE_SET_ARRAY_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    function automatic cache_line_t mk(input int tag, input int data, input int lru, input mesi_t mesi);
        cache_line_t l;
        l.tag       = TAG_W'(tag);
        l.data      = DATA_W'(data);
        l.LRU       = LRU_W'(lru);
        l.MESI_bits = mesi;
        return l;
    endfunction

    function automatic set_t cleared_set(input int s);
        set_t r;
        for (int j = 0; j < WAYS; j++) r[j] = mk(0, s, WAYS-1-j, MESI_I);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input int s, input int tag);
        req_valid = 1'b1;
        req_op    = OP_LOOKUP;
        req_set   = SET_W'(s);
        req_tag   = TAG_W'(tag);
        step();
        req_valid = 1'b0;
    endtask

    task automatic write_set(input int s, input set_t l);
        req_valid = 1'b1;
        req_op    = OP_WRITE_SET;
        req_set   = SET_W'(s);
        wr_lines  = l;
        step();
        req_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    initial begin
        set_t base;
        set_t l;
        int   n;
        int   lru_v [8] = '{0, 1, 2, 3, 7, 4, 5, 6};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_NOP;
        req_set   = '0;
        req_tag   = '0;
        wr_lines  = '0;
        step();

        chk("reset_busy",     busy,        1);
        chk("reset_ready",    req_ready,   0);
        chk("reset_rsp_vld",  rsp_valid,   0);
        chk("reset_hit",      rsp_hit,     0);
        chk("reset_hit_way",  rsp_hit_way, 0);
        chk("reset_victim",   rsp_victim,  0);
        chk("reset_lines",    rsp_lines,   cleared_set(0));
        reset = 1'b0;

        count_busy(n);
        chk("init_sweep_len", n, 16);
        chk("init_ready",     req_ready, 1);

        lookup(5, 0);
        chk("clr5_valid",  rsp_valid,  1);
        chk("clr5_lines",  rsp_lines,  cleared_set(5));
        chk("clr5_hit",    rsp_hit,    0);
        chk("clr5_victim", rsp_victim, 0);
        step();
        chk("rsp_pulse",   rsp_valid,  0);

        // Set 3 all shared, distinct tags; way 6 carries 0xAB.
        for (int j = 0; j < WAYS; j++) base[j] = mk('h10 + j, 'h100 + j, WAYS-1-j, MESI_S);
        base[6].tag = TAG_W'('hAB);
        write_set(3, base);

        lookup(3, 'hAB);
        chk("hit_valid",   rsp_valid,   1);
        chk("hit_flag",    rsp_hit,     1);
        chk("hit_way6",    rsp_hit_way, 6);
        chk("hit_victim",  rsp_victim,  0);
        chk("hit_lines",   rsp_lines,   base);
        lookup(3, 'h12);
        chk("b2b_valid",   rsp_valid,   1);
        chk("b2b_hit",     rsp_hit,     1);
        chk("b2b_way2",    rsp_hit_way, 2);
        step();
        chk("hold_valid",  rsp_valid,   0);
        chk("hold_way",    rsp_hit_way, 2);

        req_valid = 1'b1;
        req_op    = OP_NOP;
        req_set   = 4'd3;
        step();
        req_valid = 1'b0;
        chk("nop_valid",   rsp_valid,   0);
        chk("nop_hold",    rsp_hit,     1);

        l = base;
        l[2].MESI_bits = MESI_I;
        write_set(3, l);
        lookup(3, 'hCD);
        chk("inv_hit",     rsp_hit,     0);
        chk("inv_hit_way", rsp_hit_way, 0);
        chk("inv_victim",  rsp_victim,  2);

        for (int j = 0; j < WAYS; j++) l[j] = mk('h30 + j, j, lru_v[j], MESI_M);
        write_set(3, l);
        lookup(3, 'hEE);
        chk("lru_hit",     rsp_hit,     0);
        chk("lru_victim",  rsp_victim,  4);

        l[1].tag = TAG_W'('hCD);
        l[4].tag = TAG_W'('hCD);
        write_set(3, l);
        lookup(3, 'hCD);
        chk("dual_hit",    rsp_hit,     1);
        chk("dual_low",    rsp_hit_way, 1);

        l[1].tag = TAG_W'('h31);
        l[4].MESI_bits = MESI_I;
        write_set(3, l);
        lookup(3, 'hCD);
        chk("itag_hit",    rsp_hit,     0);
        chk("itag_victim", rsp_victim,  4);

        l[4].MESI_bits = MESI_M;
        l[4].LRU = LRU_W'(2);
        write_set(3, l);
        lookup(3, 'hEE);
        chk("corrupt_victim", rsp_victim, 0);

        req_valid = 1'b1;
        req_op    = OP_CLEAR;
        step();
        chk("clr_busy",    busy,      1);
        chk("clr_ready",   req_ready, 0);
`ifdef CACHE_SET_ARRAY_STATS_EN
        chk("clr_hits0",   hit_count,  0);
        chk("clr_miss0",   miss_count, 0);
`endif
        req_op  = OP_LOOKUP;
        req_set = 4'd3;
        req_tag = TAG_W'('h31);
        count_busy(n);
        chk("clr_sweep_len", n, 16);
        chk("clr_ready_back", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("held_valid",  rsp_valid, 1);
        chk("held_lines",  rsp_lines, cleared_set(3));
        chk("held_hit",    rsp_hit,   0);

        write_set(3, base);
        lookup(3, 'hAB);
        lookup(3, 'hAB);
        lookup(3, 'hAB);
        chk("s_hit",       rsp_hit,   1);
        lookup(3, 'hCD);
        chk("s_miss",      rsp_hit,   0);
        step();
`ifdef CACHE_SET_ARRAY_STATS_EN
        chk("stat_hits",   hit_count,  3);
        chk("stat_miss",   miss_count, 2);
`endif

        req_valid = 1'b1;
        req_op    = OP_CLEAR;
        step();
        req_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_busy",    busy, 1);
`ifdef CACHE_SET_ARRAY_STATS_EN
        chk("mid_hits0",   hit_count,  0);
        chk("mid_miss0",   miss_count, 0);
`endif
        count_busy(n);
        chk("mid_sweep_len", n, 16);
        lookup(15, 0);
        chk("mid15_lines", rsp_lines, cleared_set(15));
        chk("mid15_hit",   rsp_hit,   0);
        lookup(3, 'hAB);
        chk("mid3_lines",  rsp_lines, cleared_set(3));
        chk("mid3_hit",    rsp_hit,   0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
